// File: rtl/bcd_display_driver.sv
// bcd_display_driver: captures a print strobe, converts the value to BCD by
// double-dabble, and scans a blanked 4-digit 7-segment display.
module bcd_display_driver #(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       print_n,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy,
    output logic       overrun
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t          state, state_nxt;
    logic            prev_n, capture, load;
    logic [19:0]     sr, adj;
    logic [2:0]      cnt;
    logic [3:0]      hund, tens, ones, dig;
    logic            loaded, blank;
    logic [CW-1:0]   scan;
    logic [1:0]      idx;
    logic [6:0]      seg_q, code;
    logic [3:0]      an_q;

    function automatic logic [3:0] nib(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign capture = !print_n && prev_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE && capture)      ? CONV :
                    (state == CONV && cnt == 3'd7)  ? LOAD :
                    (state == LOAD)                 ? IDLE : state;
    end

    always_comb begin
        busy = (state != IDLE);
        load = (state == LOAD);
    end

    always_comb begin
        adj   = {nib(sr[19:16]), nib(sr[15:12]), nib(sr[11:8]), sr[7:0]};
        dig   = (idx == 2'd0) ? ones : (idx == 2'd1) ? tens : hund;
        blank = !loaded || idx == 2'd3 || (idx == 2'd2 && hund == 4'd0) ||
                (idx == 2'd1 && hund == 4'd0 && tens == 4'd0);
        code  = blank ? 7'h7F : SEG_LUT[dig];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_n  <= 1'b1;
            overrun <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            hund    <= '0;
            tens    <= '0;
            ones    <= '0;
            loaded  <= 1'b0;
            scan    <= '0;
            idx     <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'b1110;
        end else begin
            prev_n <= print_n;
            if (capture && busy) overrun <= 1'b1;
            if (capture && !busy) begin
                sr  <= {12'b0, value};
                cnt <= '0;
            end
            if (state == CONV) begin
                sr  <= adj << 1;
                cnt <= cnt + 3'd1;
            end
            if (load) begin
                hund   <= sr[19:16];
                tens   <= sr[15:12];
                ones   <= sr[11:8];
                loaded <= 1'b1;
            end
            if (scan == CW'(REFRESH_DIV - 1)) begin
                scan <= '0;
                idx  <= idx + 2'd1;
            end else begin
                scan <= scan + 1'b1;
            end
            // seg and an come from the same index so they always switch together
            seg_q <= code;
            an_q  <= ~(4'b0001 << idx);
        end
    end

    assign seg = SEG_ACTIVE_LOW ? seg_q : ~seg_q;
    assign an  = SEG_ACTIVE_LOW ? an_q : ~an_q;
    assign dp  = SEG_ACTIVE_LOW;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: scoreboard bench driving two polarities of the display driver.
module tb_bcd_display_driver;
    logic       clk = 1'b0, rst = 1'b1, print_n = 1'b1;
    logic [7:0] value = '0;
    logic [6:0] seg, seg2;
    logic [3:0] an, an2;
    logic       dp, dp2, busy, busy2, overrun, overrun2;

    typedef struct packed {
        logic [27:0] segs;
        logic        abort;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    bit   mon_busy = 1'b0;

    localparam logic [6:0] LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    always #5 clk = ~clk;

    bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .print_n(print_n), .value(value),
        .seg(seg), .dp(dp), .an(an), .busy(busy), .overrun(overrun)
    );

    bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) dut2 (
        .clk(clk), .rst(rst), .print_n(print_n), .value(value),
        .seg(seg2), .dp(dp2), .an(an2), .busy(busy2), .overrun(overrun2)
    );

    // Expected active-low patterns, digit 3 in the top bits, digit 0 at the bottom
    function automatic logic [27:0] model(input int v);
        return {7'h7F, (v >= 100) ? LUT[v / 100] : 7'h7F,
                (v >= 10) ? LUT[(v / 10) % 10] : 7'h7F, LUT[v % 10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic strobe(input logic [7:0] v, input int len);
        @(posedge clk);
        #1 print_n = 1'b0;
        value = v;
        repeat (len) @(posedge clk);
        #1 print_n = 1'b1;
    endtask

    task automatic settle();
        int n = 0;
        while ((q.size() != 0 || mon_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL settle timeout");
        end
    endtask

    task automatic run(input int v);
        q.push_back('{model(v), 1'b0});
        strobe(8'(v), 1);
        settle();
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t       e;
        int         n;
        bit         seen_b, busy_hi, dp_bad;
        logic [6:0] s1 [4], s2 [4];
        bit         ok1 [4], ok2 [4];
        logic [3:0] oh;
        forever begin
            while (q.size() == 0) @(negedge clk);
            mon_busy = 1'b1;
            e = q.pop_front();
            seen_b = 1'b0;
            for (int i = 0; i < 40 && !seen_b; i++) begin
                @(negedge clk);
                seen_b = busy;
            end
            if (!seen_b) begin
                checks++;
                errors++;
                $display("FAIL busy_start timeout");
            end else begin
                n = 0;
                while (busy && n < 40) begin
                    n++;
                    @(negedge clk);
                end
                if (!e.abort) chk("busy_len", n, 9);
            end
            repeat (20) @(negedge clk);
            busy_hi = 1'b0;
            dp_bad  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ok1[i] = 1'b0;
                ok2[i] = 1'b0;
                s1[i]  = '0;
                s2[i]  = '0;
            end
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    oh = 4'b0001 << i;
                    if (an == ~oh) begin s1[i] = seg;  ok1[i] = 1'b1; end
                    if (an2 == oh) begin s2[i] = ~seg2; ok2[i] = 1'b1; end
                end
                busy_hi |= busy | busy2;
                dp_bad  |= (dp !== 1'b1) | (dp2 !== 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("seg_d%0d", i), {ok1[i], s1[i]}, {1'b1, e.segs[i*7 +: 7]});
                chk($sformatf("seg_inv_d%0d", i), {ok2[i], s2[i]}, {1'b1, e.segs[i*7 +: 7]});
            end
            chk("busy_idle", busy_hi, 0);
            chk("dp", dp_bad, 0);
            mon_busy = 1'b0;
        end
    end

    initial begin : stim
        int v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'b1110);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dp", dp, 1);
        chk("rst_seg_inv", seg2, 7'h00);
        chk("rst_an_inv", an2, 4'b0001);
        chk("rst_dp_inv", dp2, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run(173);
        run(5);
        run(0);
        run(255);

        q.push_back('{model(42), 1'b0});
        strobe(8'd42, 20);
        settle();
        chk("overrun_hold", overrun, 0);

        q.push_back('{model(42), 1'b0});
        strobe(8'd42, 1);
        @(posedge clk);
        strobe(8'd99, 1);
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        chk("overrun_set_inv", overrun2, 1);
        settle();
        chk("overrun_sticky", overrun, 1);

        pulse_rst();
        @(negedge clk);
        chk("overrun_cleared", overrun, 0);
        q.push_back('{model(77), 1'b0});
        strobe(8'd77, 1);
        repeat (7) @(posedge clk);
        strobe(8'd11, 1);
        @(negedge clk);
        chk("overrun_load_edge", overrun, 1);
        settle();

        q.push_back('{28'hFFFFFFF, 1'b1});
        strobe(8'd123, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", busy, 0);
        chk("overrun_after_rst", overrun, 0);
        settle();

        run(7);
        run(8);
        run(10);
        run(100);
        for (int k = 0; k < 15; k++) begin
            v = int'($urandom_range(0, 255));
            run(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Output stage of the processor, downstream of the control FSM. When the FSM enters its print state, it drives its active-low print strobe low for one cycle. On that strobe, this block captures the 8-bit result from the datapath. It converts the result to three BCD digits with a sequential double-dabble engine, one shift per clock, and drives a time-multiplexed 4-digit 7-segment display with leading-zero blanking.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit (legal range ≥2).
- SEG_ACTIVE_LOW, 1: 1 = seg/dp/an active-low; 0 = all three inverted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- print_n  in  1  active-low print strobe from the control FSM.
- value  in  8  unsigned result to display; sampled only on capture.
- seg  out  7  segment drive {g,f,e,d,c,b,a}.
- dp  out  1  decimal point; never lit.
- an  out  4  digit enables; an[0] is the rightmost digit.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  sticky; set when a strobe is dropped.

## Operation
- Capture condition: print_n==0 and prev_n==1, where prev_n is the registered print_n and resets to 1.
  - Falling-edge detect, so a strobe held low for many cycles produces exactly one capture.
- Converter FSM states: IDLE, CONV, LOAD.
  - IDLE: on capture, shift reg <= {12'b0, value}, iteration count <= 0, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift the 20-bit register left by 1, then count++.
    - After the 8th shift, go to LOAD.
  - LOAD: copy the hundreds/tens/ones nibbles into the display registers, go to IDLE.
- busy = (state != IDLE), registered.
- Capture while busy: the strobe is ignored, the converter is unaffected, and overrun <= 1.
  - overrun is cleared only by rst.
- Scan counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- Digit content:
  - Index 0: ones.
  - Index 1: tens; blank if hundreds==0 and tens==0.
  - Index 2: hundreds; blank if 0.
  - Index 3: always blank.
- Encoding, active-low gfedcba:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19.
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - blank=0x7F.
- an (active-low) = ~(4'b0001 << index).
- When SEG_ACTIVE_LOW=0, seg, dp and an are bitwise inverted.
- Until the first LOAD after reset, all digits are blank.

## Timing
- Reset values (next edge with rst=1):
  - busy=0, overrun=0, prev_n=1, state=IDLE.
  - index=0, scan counter=0, display registers=blank.
  - seg=0x7F, dp=1, an=4'b1110 (polarity-adjusted when SEG_ACTIVE_LOW=0).
- Capture at cycle T (edge condition true on that cycle's rising edge):
  - busy is high T+1..T+9: 8 CONV cycles, then 1 LOAD cycle.
  - Display registers update at the edge ending T+9.
  - busy=0 and a new capture is accepted from T+10.
- seg/an are registered and change together one cycle after the index changes. No cycle shows a new an with the old seg.
- A capture on the same edge that LOAD completes is dropped: state is not yet IDLE, so overrun is set.
- rst during CONV or LOAD:
  - The conversion is aborted and the display reverts to blank.
  - No partial value is ever shown.
- Scan is free-running and independent of conversion; a LOAD takes effect on the next refresh of each digit.

## Test plan
- Reset: assert rst 2 cycles → seg=0x7F, an=4'b1110, busy=0, overrun=0, dp=1.
- REFRESH_DIV=4, value=173, print_n low 1 cycle → busy high exactly 9 cycles. Scan then shows:
  - an=1110: seg=0x30.
  - an=1101: seg=0x78.
  - an=1011: seg=0x79.
  - an=0111: seg=0x7F.
- Blanking:
  - value=5 → 0x12 / 0x7F / 0x7F / 0x7F.
  - value=0 → 0x40 on digit 0, rest 0x7F.
  - value=255 → 0x12 / 0x12 / 0x24 / 0x7F.
- Strobe rules:
  - print_n held low 20 cycles with value=42 → one capture only; busy pulses 9 cycles once.
  - A second falling edge 3 cycles after the first capture (value=99) → overrun=1; display shows 42.
- Reset mid-operation: rst at the 4th CONV cycle → next cycle busy=0, all digits blank.
  - A subsequent print of 7 converts normally: 0x78 on digit 0.
- SEG_ACTIVE_LOW=0, value=8 → digit 0 seg=0x7F, an=4'b0001, dp=0.
